spi_reg_slave: RTL and testbench
================================

Name: spi_reg_slave

Overview:
- Parametrised SPI slave (mode 0: CPOL=0, CPHA=0), successor to the fixed 8-bit single-word slave.
- Adds configurable word width, a command/address phase, multi-word burst read/write and an internal register bank of 2**ADDR_W words.
- Sits between the Arduino master and FPGA control logic (e.g. PWM duty/period registers); the bank contents are exported as a flat bus.

Parameters:
- DATA_W, 8, bits per SPI word; also the register width; minimum 2.
- ADDR_W, 4, address bits; the bank holds 2**ADDR_W registers; requires ADDR_W <= DATA_W-1.

Ports:
- SCLK  input  1  SPI clock from master; sole clock of the block (posedge and negedge used).
- rst  input  1  asynchronous, active-high reset.
- ss  input  1  slave select, active low.
- MOSI  input  1  master out, slave in; sampled on posedge SCLK.
- MISO  output  1  master in, slave out; updated on negedge SCLK; always driven (no tristate).
- reg_out  output  DATA_W*2**ADDR_W  flat register bank; register k occupies bits [k*DATA_W +: DATA_W].
- wr_strobe  output  1  high for one SCLK period after a completed write word.
- wr_addr  output  ADDR_W  address of the last written register; valid while wr_strobe is high.
- partial_abort  output  1  high for one SCLK period when ss rises with a partial word in progress.

Behaviour:
- Reset, asynchronous: state=IDLE, bit_cnt=0, shift_reg=0, addr=0, all registers 0, MISO=0, wr_strobe=0, wr_addr=0, partial_abort=0. Reset mid-frame discards the frame and does not preserve the bank.
- States: IDLE, CMD, WR, RD.
- Bit handling, posedge SCLK with ss low:
  - shift_reg <= {shift_reg[DATA_W-2:0], MOSI}, MSB first.
  - bit_cnt increments and wraps to 0 after DATA_W-1.
  - A word is complete at the posedge where bit_cnt==DATA_W-1; word = {shift_reg[DATA_W-2:0], MOSI}.
- IDLE -> CMD on the first posedge with ss low; that posedge captures bit 0.
- Command word, on completion:
  - rw = word[DATA_W-1]: 1 = read, 0 = write.
  - addr = word[ADDR_W-1:0]; the remaining bits are ignored.
  - Next state is RD if rw=1, otherwise WR.
  - On a read, tx_word <= reg[addr] at the same posedge.
- WR, on each completed word:
  - reg[addr] <= word, wr_addr <= addr, wr_strobe <= 1.
  - addr <= addr+1, wrapping from 2**ADDR_W-1 to 0.
  - wr_strobe clears at the next posedge.
- RD, on each completed word: addr <= addr+1 (wraps) and tx_word <= reg[addr+1]. The bank is not modified.
- MISO, negedge SCLK:
  - In RD with ss low: MISO <= tx_word[DATA_W-1-bit_cnt].
  - Otherwise MISO <= 0, so the command phase returns zeros.
  - The first data bit is therefore valid before the first posedge of the data word.
- ss high at posedge SCLK:
  - state <= IDLE, bit_cnt <= 0; rx shift contents are discarded.
  - If bit_cnt != 0, partial_abort <= 1 for that SCLK period and no write occurs.
  - A partial command leaves addr unchanged.
- ss high at negedge SCLK: MISO <= 0.
- The block has no other clock, so deselect is only acted on at an SCLK edge. The master must issue at least one SCLK edge with ss high before the next frame, or the previous frame continues.
- Burst length is unlimited; the address wraps continuously.

Optional Feature:
- Macro: SPI_AUTOINC_EN.
- Defined: address auto-increments after each data word, as described above.
- Undefined: addr holds the command address for the whole frame. Repeated writes overwrite the same register; repeated reads return the same register.

Decomposition:
- Package spi_reg_pkg contains:
  - state enum (IDLE, CMD, WR, RD);
  - CMD_RW_BIT = DATA_W-1 (function/localparam);
  - helper function for flat-bus register slicing.
- Sub-module spi_reg_bank: 2**ADDR_W x DATA_W registers with async reset, a write port (we, waddr, wdata), a combinational read port, and the flat reg_out. The top contains the shift/FSM/MISO logic.

Test Plan (DATA_W=8, ADDR_W=4, SPI_AUTOINC_EN defined unless noted):
- Write burst: ss low, MOSI 0x03, 0xA5, 0x5A, ss high -> reg3=0xA5, reg4=0x5A; wr_strobe twice, with wr_addr 3 then 4; MISO=0 throughout.
- Read burst after the write burst: MOSI 0x83, then 16 clocks -> MISO shows 0xA5 then 0x5A MSB first; the bank is unchanged.
- Wrap: write 0x0F, 0x11, 0x22 -> reg15=0x11, reg0=0x22; a read of 0x8F with 2 words returns 0x11, 0x22.
- Abort: command 0x05, then 5 data bits, then ss high for one posedge -> partial_abort pulses once, reg5 is unchanged, and the next frame decodes normally.
- Reset mid-frame: assert rst during the 3rd data bit -> all outputs and registers are 0 immediately; after release, a new 0x01/0x77 write gives reg1=0x77.
- SPI_AUTOINC_EN undefined: write 0x02, 0x10, 0x20 -> reg2=0x20, reg3=0x00; wr_addr=2 on both strobes.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register slave: FSM state encoding,
// command-word field positions and flat register-bus slicing.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } spi_state_e;

  // The read/write flag is the MSB of the command word.
  function automatic int cmd_rw_bit(input int data_w);
    return data_w - 1;
  endfunction

  // LSB position of register k inside the flat bank bus.
  function automatic int reg_lsb(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// Register bank for the SPI slave: one synchronous write port, one
// combinational read port and the whole bank exported as a flat bus.
module spi_reg_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                         SCLK,
  input  logic                         rst,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [ADDR_W-1:0]            raddr,
  output logic [DATA_W-1:0]            rdata,
  output logic [DATA_W*(2**ADDR_W)-1:0] reg_out
);
  import spi_reg_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign reg_out[reg_lsb(k, DATA_W) +: DATA_W] = mem[k];
  end

endmodule

// File: rtl/spi_reg_slave.sv
// Mode-0 SPI slave with a command/address word followed by burst data words
// into or out of a register bank. SPI_AUTOINC_EN enables address auto-increment.
module spi_reg_slave #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                          SCLK,
  input  logic                          rst,
  input  logic                          ss,
  input  logic                          MOSI,
  output logic                          MISO,
  output logic [DATA_W*(2**ADDR_W)-1:0] reg_out,
  output logic                          wr_strobe,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic                          partial_abort
);
  import spi_reg_pkg::*;

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam int              RW_BIT   = cmd_rw_bit(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_state_e        state, state_n;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] shift_reg;
  logic [DATA_W-1:0] word, tx_word, rdata;
  logic [ADDR_W-1:0] addr, addr_n, addr_step, raddr;
  logic              word_done, bank_we, tx_load;

  // Only DATA_W-1 bits are held; the final bit comes straight from MOSI.
  assign word      = {shift_reg, MOSI};
  assign word_done = !ss && (bit_cnt == LAST_BIT);

`ifdef SPI_AUTOINC_EN
  assign addr_step = addr + ADDR_W'(1);
`else
  assign addr_step = addr;
`endif

  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (ss) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    state_n = CMD;
        CMD:     if (word_done) state_n = word[RW_BIT] ? RD : WR;
        default: state_n = state;
      endcase
    end
  end

  always_comb begin
    bank_we = 1'b0;
    tx_load = 1'b0;
    addr_n  = addr;
    raddr   = addr;
    if (word_done) begin
      case (state)
        CMD: begin
          addr_n  = word[ADDR_W-1:0];
          raddr   = word[ADDR_W-1:0];
          tx_load = word[RW_BIT];
        end
        WR: begin
          bank_we = 1'b1;
          addr_n  = addr_step;
        end
        RD: begin
          addr_n  = addr_step;
          raddr   = addr_step;
          tx_load = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Deselect at a posedge drops any partial word; only a mid-word drop is flagged.
  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      bit_cnt       <= '0;
      shift_reg     <= '0;
      addr          <= '0;
      tx_word       <= '0;
      wr_strobe     <= 1'b0;
      wr_addr       <= '0;
      partial_abort <= 1'b0;
    end else if (ss) begin
      bit_cnt       <= '0;
      shift_reg     <= '0;
      wr_strobe     <= 1'b0;
      partial_abort <= (bit_cnt != '0);
    end else begin
      shift_reg     <= word[DATA_W-2:0];
      bit_cnt       <= word_done ? '0 : bit_cnt + CNT_W'(1);
      addr          <= addr_n;
      wr_strobe     <= bank_we;
      partial_abort <= 1'b0;
      if (bank_we) wr_addr <= addr;
      if (tx_load) tx_word <= rdata;
    end
  end

  always_ff @(negedge SCLK or posedge rst) begin
    if (rst)                      MISO <= 1'b0;
    else if (!ss && state == RD)  MISO <= tx_word[LAST_BIT - bit_cnt];
    else                          MISO <= 1'b0;
  end

  spi_reg_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .SCLK    (SCLK),
    .rst     (rst),
    .we      (bank_we),
    .waddr   (addr),
    .wdata   (word),
    .raddr   (raddr),
    .rdata   (rdata),
    .reg_out (reg_out)
  );

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave (DATA_W=8, ADDR_W=4): directed SPI frames with a
// scoreboard for MISO words, write strobes and abort pulses.
module tb_spi_reg_slave;
  localparam int NREG = 16;
`ifdef SPI_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic         SCLK = 1'b0;
  logic         rst  = 1'b0;
  logic         ss   = 1'b1;
  logic         MOSI = 1'b0;
  logic         MISO, wr_strobe, partial_abort;
  logic [3:0]   wr_addr;
  logic [127:0] reg_out;

  spi_reg_slave #(.DATA_W(8), .ADDR_W(4)) dut (
    .SCLK          (SCLK),
    .rst           (rst),
    .ss            (ss),
    .MOSI          (MOSI),
    .MISO          (MISO),
    .reg_out       (reg_out),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .partial_abort (partial_abort)
  );

  // clock / reset
  initial forever #5 SCLK = ~SCLK;

  int checks = 0;
  int failures = 0;
  int abort_seen = 0;
  int abort_exp = 0;
  logic [7:0]  mdl [NREG];
  logic [7:0]  exp_q [$];
  logic [11:0] exp_wr_q [$];
  logic [7:0]  mon_sh = '0;
  int          mon_n = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mdl_flat();
    logic [127:0] f;
    for (int k = 0; k < NREG; k++) f[k*8 +: 8] = mdl[k];
    return f;
  endfunction

  // driver tasks: master changes MOSI on the falling edge
  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      @(negedge SCLK);
      ss   = 1'b0;
      MOSI = w[i];
    end
  endtask

  task automatic end_frame();
    @(negedge SCLK);
    ss   = 1'b1;
    MOSI = 1'b0;
    @(negedge SCLK);
  endtask

  task automatic wr_frame(input logic [3:0] a, input int n, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] d [2];
    logic [3:0] ea;
    d[0] = d0;
    d[1] = d1;
    exp_q.push_back(8'h00);
    send_word({4'h0, a});
    for (int i = 0; i < n; i++) begin
      ea = AUTOINC ? a + 4'(i) : a;
      mdl[ea] = d[i];
      exp_wr_q.push_back({ea, d[i]});
      exp_q.push_back(8'h00);
      send_word(d[i]);
    end
    end_frame();
  endtask

  task automatic rd_frame(input logic [3:0] a, input int n);
    logic [3:0] ea;
    exp_q.push_back(8'h00);
    send_word({4'h8, a});
    for (int i = 0; i < n; i++) begin
      ea = AUTOINC ? a + 4'(i) : a;
      exp_q.push_back(mdl[ea]);
      send_word(8'h00);
    end
    end_frame();
  endtask

  // scoreboard monitor: samples away from both SCLK edges
  always @(negedge SCLK) begin
    logic [11:0] e;
    #2;
    if (rst) begin
      mon_n = 0;
    end else begin
      if (wr_strobe) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_strobe_unexpected: got addr %0h expected no strobe", wr_addr);
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_addr", wr_addr, e[11:8]);
          check("wr_data", reg_out[int'(e[11:8])*8 +: 8], e[7:0]);
        end
      end
      if (partial_abort) abort_seen++;
      if (!ss) begin
        mon_sh = {mon_sh[6:0], MISO};
        mon_n++;
        if (mon_n == 8) begin
          mon_n = 0;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL miso_unexpected: got %0h expected no word", mon_sh);
          end else begin
            check("miso_word", mon_sh, exp_q.pop_front());
          end
        end
      end else begin
        mon_n = 0;
      end
    end
  end

  initial begin
    for (int k = 0; k < NREG; k++) mdl[k] = 8'h00;
    #1 rst = 1'b1;
    #2;
    check("reset_reg_out", reg_out, 128'd0);
    check("reset_miso", MISO, 1'b0);
    check("reset_wr_strobe", wr_strobe, 1'b0);
    check("reset_wr_addr", wr_addr, 4'h0);
    check("reset_abort", partial_abort, 1'b0);
    repeat (2) @(negedge SCLK);
    rst = 1'b0;
    @(negedge SCLK);

    // write burst then read-back
    wr_frame(4'h3, 2, 8'hA5, 8'h5A);
    check("burst_reg3", reg_out[31:24], AUTOINC ? 8'hA5 : 8'h5A);
    check("burst_reg4", reg_out[39:32], AUTOINC ? 8'h5A : 8'h00);
    check_bank_after("bank_after_write");
    rd_frame(4'h3, 2);
    check("bank_after_read", reg_out, mdl_flat());
    check("miso_idle", MISO, 1'b0);

    // address wrap
    wr_frame(4'hF, 2, 8'h11, 8'h22);
    check("wrap_reg15", reg_out[127:120], AUTOINC ? 8'h11 : 8'h22);
    check("wrap_reg0", reg_out[7:0], AUTOINC ? 8'h22 : 8'h00);
    rd_frame(4'hF, 2);

    // partial data word aborts without writing
    exp_q.push_back(8'h00);
    send_word(8'h05);
    for (int i = 0; i < 5; i++) begin
      @(negedge SCLK);
      MOSI = i[0];
    end
    abort_exp++;
    end_frame();
    check("abort_reg5", reg_out[47:40], 8'h00);
    wr_frame(4'h5, 1, 8'hC3, 8'h00);
    check("post_abort_reg5", reg_out[47:40], 8'hC3);

    // no-increment pattern from address 2
    wr_frame(4'h2, 2, 8'h10, 8'h20);
    check("inc_reg2", reg_out[23:16], AUTOINC ? 8'h10 : 8'h20);
    rd_frame(4'h2, 2);
    check("bank_mid", reg_out, mdl_flat());

    // reset during the third data bit of a write
    exp_q.push_back(8'h00);
    send_word(8'h01);
    @(negedge SCLK); MOSI = 1'b0;
    @(negedge SCLK); MOSI = 1'b1;
    @(negedge SCLK); MOSI = 1'b1;
    #3 rst = 1'b1;
    #1;
    check("midrst_reg_out", reg_out, 128'd0);
    check("midrst_miso", MISO, 1'b0);
    check("midrst_wr_strobe", wr_strobe, 1'b0);
    check("midrst_wr_addr", wr_addr, 4'h0);
    check("midrst_abort", partial_abort, 1'b0);
    @(negedge SCLK);
    ss = 1'b1;
    MOSI = 1'b0;
    @(negedge SCLK);
    rst = 1'b0;
    for (int k = 0; k < NREG; k++) mdl[k] = 8'h00;
    @(negedge SCLK);
    wr_frame(4'h1, 1, 8'h77, 8'h00);
    check("post_rst_reg1", reg_out[15:8], 8'h77);
    check("post_rst_bank", reg_out, mdl_flat());

    repeat (3) @(negedge SCLK);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("miso_queue_drained", exp_q.size(), 0);
    check("abort_count", abort_seen, abort_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic check_bank_after(input string name);
    check(name, reg_out, mdl_flat());
  endtask

endmodule
